// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator for the decode stage. Each accepted 32-bit
//   instruction is decoded combinationally. The immediate, the format code, the
//   illegal-opcode flag and a sideband tag are written into a 2-entry FIFO.
//   The out_* ports always show the FIFO head. in_ready is registered and
//   stays high while the FIFO can still accept, so a stream flows at one
//   instruction per cycle.
//   XLEN must be 32 or 64.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   flush        synchronous clear of all buffered entries (same-cycle push dropped)
//   in_valid     instruction presented
//   in_ready     block can accept (registered, count < 2)
//   in_instr     32-bit instruction word
//   in_tag       sideband tag (typically the PC)
//   out_valid    head entry valid
//   out_ready    consumer accepts the head entry
//   out_imm      decoded immediate, XLEN bits
//   out_fmt      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSRZ
//   out_illegal  opcode not recognised
//   out_tag      tag of the head entry
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_CSRZ  = 3'd7
  } fmt_e;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // A size cast of a signed operand sign-extends it to XLEN.
  assign imm_i    = XLEN'($signed(in_instr[31:20]));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111: begin          // LOAD, JALR
        dec_fmt = FMT_I;
        dec_imm = imm_i;
      end
      7'b0010011: begin                      // OP-IMM
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          // RV64 shifts use a 6-bit amount. Upper funct bits are never part of it.
          if (XLEN == 64) dec_imm = XLEN'(in_instr[25:20]);
          else            dec_imm = XLEN'(in_instr[24:20]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end
      end
      7'b0011011: begin                      // OP-IMM-32, RV64 only
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_fmt = FMT_SHAMT;
            dec_imm = XLEN'(in_instr[24:20]);
          end else begin
            dec_fmt = FMT_I;
            dec_imm = imm_i;
          end
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0100011: begin                      // STORE
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin                      // BRANCH
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      7'b1101111: begin                      // JAL
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin          // LUI, AUIPC
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1110011: begin                      // SYSTEM
        case (funct3)
          3'b100: dec_illegal = 1'b1;
          3'b101, 3'b110, 3'b111: begin
            dec_fmt = FMT_CSRZ;
            dec_imm = XLEN'(in_instr[19:15]);
          end
          3'b001, 3'b010, 3'b011: begin
            dec_fmt = FMT_I;
            dec_imm = imm_i;
          end
          default: ;                         // ECALL/EBREAK/xRET: no immediate
        endcase
      end
      7'b0110011, 7'b0001111: ;              // OP, FENCE: legal, no immediate
      7'b0111011: dec_illegal = (XLEN != 64);  // OP-32
      default: dec_illegal = 1'b1;           // also covers instr[1:0] != 2'b11
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  imm_q [2];
  logic [2:0]       fmt_q [2];
  logic             ill_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             push;
  logic             pop;

  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
      // NOTE: the storage is cleared as well because the head entry drives
      // out_* directly and those outputs must read as zero after reset.
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= '0;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        imm_q[wr_ptr] <= dec_imm;
        fmt_q[wr_ptr] <= dec_fmt;
        ill_q[wr_ptr] <= dec_illegal;
        tag_q[wr_ptr] <= in_tag;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      in_ready <= (count_nxt < 2'd2);
    end
  end

  assign out_valid   = (count != 2'd0);
  assign out_imm     = imm_q[rd_ptr];
  assign out_fmt     = fmt_q[rd_ptr];
  assign out_illegal = ill_q[rd_ptr];
  assign out_tag     = tag_q[rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Directed bench for imm_gen_pipe. It uses a 32-bit and a 64-bit instance
//   that share every input, and it compares both against hand-computed
//   expected values.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic [2:0]  out_fmt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  // Directed decode vectors: instruction, then expectations for XLEN=32 and XLEN=64.
  localparam int NV = 13;
  localparam logic [31:0] V_INSTR [NV] = '{
    32'hFFF00093,  // addi x1,x0,-1
    32'hFE000EE3,  // beq x0,x0,-4
    32'hFFC08067,  // jalr x0,-4(x1)
    32'h4030D093,  // srai x1,x1,3
    32'h3002D073,  // csrrwi x0,mstatus,5
    32'h0000007F,  // unknown opcode
    32'h80000537,  // lui x10,0x80000
    32'h01F0909B,  // slliw x1,x1,31 (illegal on RV32)
    32'hFFDFF06F,  // jal x0,-4
    32'hFE002C23,  // sw x0,-8(x0)
    32'h03F09093,  // slli x1,x1,63 (bit 25 only counts on RV64)
    32'h00000073,  // ecall
    32'h00004073   // SYSTEM funct3=100
  };
  localparam logic [2:0]  V_FMT32 [NV] = '{1, 3, 1, 6, 7, 0, 4, 0, 5, 2, 6, 0, 0};
  localparam logic [31:0] V_IMM32 [NV] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'd3, 32'd5, 32'd0, 32'h80000000,
    32'd0, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'd31, 32'd0, 32'd0
  };
  localparam logic        V_ILL32 [NV] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1};
  localparam logic [2:0]  V_FMT64 [NV] = '{1, 3, 1, 6, 7, 0, 4, 6, 5, 2, 6, 0, 0};
  localparam logic [63:0] V_IMM64 [NV] = '{
    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'd3, 64'd5,
    64'd0, 64'hFFFFFFFF80000000, 64'd31, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
    64'd63, 64'd0, 64'd0
  };
  localparam logic        V_ILL64 [NV] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

  // Advance one clock edge; outputs are then read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b/%b exp=0", out_valid32, out_valid64);
    end
    total++; if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b/%b exp=1", in_ready32, in_ready64);
    end
    total++; if (out_imm32 !== '0 || out_fmt32 !== '0 || out_illegal32 !== 1'b0 || out_tag32 !== '0) begin
      bad++; $display("FAIL reset_outputs32 got imm=%h fmt=%0d ill=%b tag=%h exp all 0",
                      out_imm32, out_fmt32, out_illegal32, out_tag32);
    end
    total++; if (out_imm64 !== '0 || out_fmt64 !== '0 || out_illegal64 !== 1'b0 || out_tag64 !== '0) begin
      bad++; $display("FAIL reset_outputs64 got imm=%h fmt=%0d ill=%b tag=%h exp all 0",
                      out_imm64, out_fmt64, out_illegal64, out_tag64);
    end
  endtask

  // Streams all vectors back to back with out_ready high, so each vector is
  // at the head exactly one cycle after being presented.
  task automatic test_decode_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_instr = V_INSTR[i];
      in_tag   = 32'h1000 + 32'(4 * i);
      tick();
      total++; if (out_valid32 !== 1'b1 || out_valid64 !== 1'b1 || in_ready32 !== 1'b1) begin
        bad++; $display("FAIL stream_valid[%0d] got v32=%b v64=%b rdy=%b exp 1/1/1",
                        i, out_valid32, out_valid64, in_ready32);
      end
      total++; if (out_imm32 !== V_IMM32[i] || out_fmt32 !== V_FMT32[i] || out_illegal32 !== V_ILL32[i]) begin
        bad++; $display("FAIL decode32[%0d] instr=%h got imm=%h fmt=%0d ill=%b exp imm=%h fmt=%0d ill=%b",
                        i, V_INSTR[i], out_imm32, out_fmt32, out_illegal32, V_IMM32[i], V_FMT32[i], V_ILL32[i]);
      end
      total++; if (out_imm64 !== V_IMM64[i] || out_fmt64 !== V_FMT64[i] || out_illegal64 !== V_ILL64[i]) begin
        bad++; $display("FAIL decode64[%0d] instr=%h got imm=%h fmt=%0d ill=%b exp imm=%h fmt=%0d ill=%b",
                        i, V_INSTR[i], out_imm64, out_fmt64, out_illegal64, V_IMM64[i], V_FMT64[i], V_ILL64[i]);
      end
      total++; if (out_tag32 !== 32'h1000 + 32'(4 * i) || out_tag64 !== 32'h1000 + 32'(4 * i)) begin
        bad++; $display("FAIL tag[%0d] got=%h/%h exp=%h", i, out_tag32, out_tag64, 32'h1000 + 32'(4 * i));
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid32 !== 1'b0) begin
      bad++; $display("FAIL stream_drain got out_valid=%b exp=0", out_valid32);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093; in_tag = 32'hA;    // A: addi, imm -1
    tick();
    total++; if (out_valid32 !== 1'b1 || in_ready32 !== 1'b1 || out_tag32 !== 32'hA) begin
      bad++; $display("FAIL bp_first got v=%b rdy=%b tag=%h exp 1/1/a", out_valid32, in_ready32, out_tag32);
    end
    in_instr = 32'h80000537; in_tag = 32'hB;     // B: lui
    tick();
    total++; if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
      bad++; $display("FAIL bp_full_ready got=%b/%b exp=0", in_ready32, in_ready64);
    end
    in_instr = 32'h4030D093; in_tag = 32'hC;     // C: srai, held off
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_tag32 !== 32'hA || out_imm32 !== 32'hFFFFFFFF || out_fmt32 !== 3'd1 ||
                   out_valid32 !== 1'b1 || in_ready32 !== 1'b0) begin
        bad++; $display("FAIL bp_stable[%0d] got tag=%h imm=%h fmt=%0d v=%b rdy=%b exp a/ffffffff/1/1/0",
                        k, out_tag32, out_imm32, out_fmt32, out_valid32, in_ready32);
      end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_tag32 !== 32'hB || out_imm32 !== 32'h80000000 || out_fmt32 !== 3'd4 || in_ready32 !== 1'b1) begin
      bad++; $display("FAIL bp_drain_b got tag=%h imm=%h fmt=%0d rdy=%b exp b/80000000/4/1",
                      out_tag32, out_imm32, out_fmt32, in_ready32);
    end
    tick();                                      // C accepted while B pops
    in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b1 || out_tag32 !== 32'hC || out_imm32 !== 32'd3 || out_fmt32 !== 3'd6) begin
      bad++; $display("FAIL bp_drain_c got v=%b tag=%h imm=%h fmt=%0d exp 1/c/3/6",
                      out_valid32, out_tag32, out_imm32, out_fmt32);
    end
    tick();
    total++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
      bad++; $display("FAIL bp_empty got=%b/%b exp=0 (duplicate entry)", out_valid32, out_valid64);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093; in_tag = 32'h21; tick();
    in_tag    = 32'h22; tick();
    total++; if (in_ready32 !== 1'b0) begin
      bad++; $display("FAIL flush_setup_full got in_ready=%b exp=0", in_ready32);
    end
    flush = 1'b1; in_tag = 32'hDD;
    tick();
    flush = 1'b0;
    total++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
      bad++; $display("FAIL flush_clear got v=%b/%b rdy=%b/%b exp v=0 rdy=1",
                      out_valid32, out_valid64, in_ready32, in_ready64);
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid32 !== 1'b0) begin
      bad++; $display("FAIL flush_push_dropped got out_valid=%b exp=0", out_valid32);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 32'hEE;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b1 || out_tag32 !== 32'hEE || out_fmt32 !== 3'd3) begin
      bad++; $display("FAIL flush_after got v=%b tag=%h fmt=%0d exp 1/ee/3", out_valid32, out_tag32, out_fmt32);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h80000537; in_tag = 32'h31; tick();
    in_tag    = 32'h32; tick();
    rst = 1'b1; flush = 1'b1; in_tag = 32'h33;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_imm32 !== '0 || out_fmt32 !== '0 ||
                 out_illegal32 !== 1'b0 || out_tag32 !== '0) begin
      bad++; $display("FAIL midrst32 got v=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%h exp 0/1/0/0/0/0",
                      out_valid32, in_ready32, out_imm32, out_fmt32, out_illegal32, out_tag32);
    end
    total++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_imm64 !== '0 || out_tag64 !== '0) begin
      bad++; $display("FAIL midrst64 got v=%b rdy=%b imm=%h tag=%h exp 0/1/0/0",
                      out_valid64, in_ready64, out_imm64, out_tag64);
    end
  endtask

  initial begin
    test_reset();
    test_decode_stream();
    test_backpressure();
    test_flush();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and extracts the XLEN-wide immediate. It also reports the instruction format and an illegal-opcode flag, and carries a sideband tag (typically the PC). A 2-entry output buffer decouples it from the execute stage; in_ready is registered and full throughput is sustained.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal.
TAG_W, 32, width of the sideband tag carried alongside each instruction.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous clear of all buffered entries.
in_valid  input  1  instruction presented.
in_ready  output  1  block can accept; registered, equals (count < 2).
in_instr  input  32  instruction word.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts head entry.
out_imm  output  XLEN  decoded immediate.
out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSRZ.
out_illegal  output  1  opcode not recognised.
out_tag  output  TAG_W  tag of head entry.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, out_valid=0, in_ready=1.
  - out_imm, out_fmt, out_illegal and out_tag are all 0.
  - Reset overrides flush and any transfer in the same cycle.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- Latency: an instruction accepted in cycle N appears at the outputs in cycle N+1. Decode is combinational on in_instr; the result is registered into the buffer.
- Buffer: 2-entry FIFO. out_* always reflect the head entry.
  - count update: push only, +1; pop only, −1; both, unchanged.
  - count=2: in_ready=0, so a push cannot occur.
  - count=0: out_valid=0 and out_* hold their last values. The bench must not check them in this state.
  - With out_ready held high, one instruction per cycle passes with no bubbles.
  - Stability: while out_valid=1 and out_ready=0, out_* must not change.
- flush: count←0 and out_valid←0. Any push in the same cycle is discarded. in_ready is 1 in the following cycle.
- Decode by opcode in_instr[6:0]. SE(x) means sign-extend x to XLEN.
  - 0000011 LOAD, 1100111 JALR: fmt I, imm = SE(instr[31:20]).
  - 0010011 OP-IMM, funct3 not 001/101: fmt I, imm = SE(instr[31:20]).
  - 0010011 OP-IMM, funct3 001/101: fmt SHAMT. XLEN=32: imm = zero-extended instr[24:20]. XLEN=64: imm = zero-extended instr[25:20]. instr[31:26] are excluded from imm.
  - 0011011 OP-IMM-32, XLEN=64 only:
    - funct3 001/101: SHAMT, imm = zero-extended instr[24:20].
    - Otherwise: I, imm = SE(instr[31:20]).
    - For XLEN=32 this opcode is illegal.
  - 0100011 STORE: fmt S, imm = SE({instr[31:25], instr[11:7]}).
  - 1100011 BRANCH: fmt B, imm = SE({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 1101111 JAL: fmt J, imm = SE({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110111 LUI, 0010111 AUIPC: fmt U, imm = SE({instr[31:12], 12'b0}). For XLEN=64 bit 31 is replicated into bits 63:32.
  - 1110011 SYSTEM:
    - funct3[2]=1: fmt CSRZ, imm = zero-extended instr[19:15].
    - funct3 in {001, 010, 011}: fmt I, imm = SE(instr[31:20]).
    - funct3=000: fmt NONE, imm=0.
    - funct3=100: fmt NONE, imm=0, illegal=1.
  - 0110011 OP, 0111011 OP-32 (XLEN=64), 0001111 FENCE: fmt NONE, imm=0, illegal=0.
  - Any other opcode: fmt NONE, imm=0, illegal=1. This includes instr[1:0] != 2'b11.

Test Plan:
- Reset then addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, illegal=0; tag is echoed.
- beq x0,x0,-4 (0xFE000EE3), then jalr x0,-4(x1) (0xFFC08067), issued back-to-back -> consecutive cycles: imm=0xFFFFFFFC fmt=3, then imm=0xFFFFFFFC fmt=1 (JALR decodes as I, not J).
- srai x1,x1,3 (0x4030D093) -> fmt=6, imm=3; csrrwi x0,mstatus,5 (0x3002D073) -> fmt=7, imm=5; opcode 0x7F -> illegal=1, imm=0.
- XLEN=64: lui x10,0x80000 (0x80000537) -> imm=0xFFFFFFFF80000000, fmt=4. slliw (0x01F0909B) -> fmt=6, imm=31.
- Backpressure: out_ready=0 while pushing 3 instructions -> in_ready drops after the 2nd, the 3rd is held, and out_* stay stable on the 1st. Raising out_ready drains all three in order with no loss or duplication.
- flush asserted with count=2 while in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed push never appears. Separately, rst asserted mid-stream -> all outputs return to 0.
